// File: rtl/ppt_controller.sv
// Pulsed-plasma-thruster fire controller: prescaled HIGH/LOW pulse train of a latched count.
// Latency: start request in IDLE -> ppt_out high after the next rising clk edge; phase timing in prescaler ticks.
// Backpressure: none; run_ppt is a level enable, deasserting it aborts to IDLE on the next edge.
// Optional feature macro: PPT_CONTINUOUS_EN (a latched count of 0 fires indefinitely).
module ppt_controller (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  clk_div,
    input  logic [15:0] period,
    input  logic [15:0] width,
    input  logic [15:0] count,
    input  logic        run_ppt,
    output logic        ppt_out,
    output logic [15:0] count_done,
    output logic        done
);

`ifdef PPT_CONTINUOUS_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        LOW      = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [4:0]  div_q, div_d;
    logic [15:0] period_q, period_d;
    logic [15:0] width_q, width_d;
    logic [15:0] count_q, count_d;
    logic [15:0] count_done_q, count_done_d;
    logic        ppt_out_q, ppt_out_d;
    logic        done_q, done_d;

    logic [31:0] presc_mask;
    logic        tick;
    logic [15:0] high_len;
    logic [15:0] low_len;
    logic        more_pulses;

    // Phase timing derived from the latched configuration only.
    always_comb begin
        // tick fires when the prescaler reaches 2^(div+1)-1, i.e. every 2^(div+1) cycles
        presc_mask  = 32'hFFFF_FFFF >> (5'd31 - div_q);
        tick        = (presc_q == presc_mask);
        // width 0 still produces a one-tick pulse
        high_len    = (width_q == 16'd0) ? 16'd1 : width_q;
        // guarded subtraction: never underflows when width >= period
        low_len     = (period_q > width_q) ? (period_q - width_q) : 16'd1;
        // continuous mode treats a latched count of zero as "never stop"
        more_pulses = (CONT_EN && (count_q == 16'd0)) || (count_done_q < count_q);
    end

    // Next-state and datapath updates; outputs registered from the next state.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        tcnt_d       = tcnt_q;
        div_d        = div_q;
        period_d     = period_q;
        width_d      = width_q;
        count_d      = count_q;
        count_done_d = count_done_q;

        case (state_q)
            IDLE: begin
                presc_d = 32'd0;
                tcnt_d  = 16'd0;
                if (run_ppt) begin
                    div_d        = clk_div;
                    period_d     = period;
                    width_d      = width;
                    count_d      = count;
                    count_done_d = 16'd0;
                    if ((count == 16'd0) && !CONT_EN) begin
                        state_d = FINISHED;
                    end else begin
                        state_d = HIGH;
                    end
                end
            end

            HIGH: begin
                if (!run_ppt) begin
                    // abort: the partial pulse is not counted
                    state_d = IDLE;
                    presc_d = 32'd0;
                    tcnt_d  = 16'd0;
                end else begin
                    presc_d = tick ? 32'd0 : (presc_q + 32'd1);
                    if (tick) begin
                        if (tcnt_q == (high_len - 16'd1)) begin
                            tcnt_d       = 16'd0;
                            count_done_d = count_done_q + 16'd1;
                            state_d      = LOW;
                        end else begin
                            tcnt_d = tcnt_q + 16'd1;
                        end
                    end
                end
            end

            LOW: begin
                if (!run_ppt) begin
                    state_d = IDLE;
                    presc_d = 32'd0;
                    tcnt_d  = 16'd0;
                end else begin
                    presc_d = tick ? 32'd0 : (presc_q + 32'd1);
                    if (tick) begin
                        if (tcnt_q == (low_len - 16'd1)) begin
                            tcnt_d  = 16'd0;
                            state_d = more_pulses ? HIGH : FINISHED;
                        end else begin
                            tcnt_d = tcnt_q + 16'd1;
                        end
                    end
                end
            end

            FINISHED: begin
                presc_d = 32'd0;
                tcnt_d  = 16'd0;
                if (!run_ppt) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ppt_out_d = (state_d == HIGH);
        done_d    = (state_d == FINISHED);
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            presc_q      <= 32'd0;
            tcnt_q       <= 16'd0;
            div_q        <= 5'd0;
            period_q     <= 16'd0;
            width_q      <= 16'd0;
            count_q      <= 16'd0;
            count_done_q <= 16'd0;
            ppt_out_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tcnt_q       <= tcnt_d;
            div_q        <= div_d;
            period_q     <= period_d;
            width_q      <= width_d;
            count_q      <= count_d;
            count_done_q <= count_done_d;
            ppt_out_q    <= ppt_out_d;
            done_q       <= done_d;
        end
    end

    assign ppt_out    = ppt_out_q;
    assign count_done = count_done_q;
    assign done       = done_q;

endmodule
